// File: rtl/demux32_route_pkg.sv
// Shared defaults and select encoding for the 1:2 result steering block.
package demux32_route_pkg;

  localparam int DEF_SIZE  = 32;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux32_route_if.sv
// Producer-side input word plus the two consumer handshakes and delivery counters.
interface demux32_route_if
  import demux32_route_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             in_sel;
  logic [SIZE-1:0]  in_data;
  logic             in_ready;
  logic             a_valid;
  logic [SIZE-1:0]  a_data;
  logic             a_ready;
  logic             b_valid;
  logic [SIZE-1:0]  b_data;
  logic             b_ready;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  modport master (
    output in_valid, in_sel, in_data, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data, cnt_a, cnt_b
  );

  modport slave (
    input  in_valid, in_sel, in_data, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data, cnt_a, cnt_b
  );

endinterface

// File: rtl/demux32_route_fifo2_sync.sv
// Two-entry synchronous FIFO; head_data is the registered oldest entry, no bypass.
module fifo2_sync
  import demux32_route_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [SIZE-1:0] push_data,
  input  logic            pop,
  output logic [SIZE-1:0] head_data,
  output logic            empty,
  output logic            full
);

  logic [SIZE-1:0] r_mem [2];
  logic            r_wrPtr;
  logic            r_rdPtr;
  logic [1:0]      r_count;
  logic            w_doPush;
  logic            w_doPop;

  assign empty     = (r_count == 2'd0);
  assign full      = (r_count == 2'd2);
  assign head_data = r_mem[r_rdPtr];
  assign w_doPush  = push && !full;
  assign w_doPop   = pop && !empty;

  // Storage is cleared on reset so an idle output reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= push_data;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_doPop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/demux32_route.sv
// Registered 1:2 steering of a result word to writeback (A) or store/forward (B),
// each side buffered by its own 2-entry FIFO with a saturating delivery counter.
module demux32_route
  import demux32_route_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic            clk,
  input logic            rst_n,
  demux32_route_if.slave bus
);

  if (DEPTH != 2) begin : g_depthCheck
    $error("demux32_route supports DEPTH = 2 only");
  end

  logic             w_emptyA;
  logic             w_emptyB;
  logic             w_fullA;
  logic             w_fullB;
  logic             w_accept;
  logic             w_pushA;
  logic             w_pushB;
  logic             w_popA;
  logic             w_popB;
  logic [CNT_W-1:0] r_cntA;
  logic [CNT_W-1:0] r_cntB;

  // Ready looks only at the selected FIFO's registered state, never at a_ready/b_ready.
  assign bus.in_ready = (bus.in_sel == SEL_B) ? !w_fullB : !w_fullA;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_pushA      = w_accept && (bus.in_sel == SEL_A);
  assign w_pushB      = w_accept && (bus.in_sel == SEL_B);
  assign w_popA       = !w_emptyA && bus.a_ready;
  assign w_popB       = !w_emptyB && bus.b_ready;

  assign bus.a_valid  = !w_emptyA;
  assign bus.b_valid  = !w_emptyB;
  assign bus.cnt_a    = r_cntA;
  assign bus.cnt_b    = r_cntB;

  fifo2_sync #(.SIZE(SIZE)) u_fifoA (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_pushA),
    .push_data (bus.in_data),
    .pop       (w_popA),
    .head_data (bus.a_data),
    .empty     (w_emptyA),
    .full      (w_fullA)
  );

  fifo2_sync #(.SIZE(SIZE)) u_fifoB (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_pushB),
    .push_data (bus.in_data),
    .pop       (w_popB),
    .head_data (bus.b_data),
    .empty     (w_emptyB),
    .full      (w_fullB)
  );

  // Delivery counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cntA <= '0;
      r_cntB <= '0;
    end else begin
      if (w_popA && (r_cntA != '1)) begin
        r_cntA <= r_cntA + CNT_W'(1);
      end
      if (w_popB && (r_cntB != '1)) begin
        r_cntB <= r_cntB + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux32_route.sv
// Scoreboard bench for demux32_route: stimulus queues expected words, a negedge
// monitor pops and compares whatever each output delivers.
module tb_demux32_route;
  import demux32_route_pkg::*;

  localparam int TB_SIZE  = 32;
  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  demux32_route_if #(.SIZE(TB_SIZE), .CNT_W(TB_CNT_W)) bus ();

  demux32_route #(.SIZE(TB_SIZE), .DEPTH(2), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          passes = 0;
  logic [31:0] qA[$];
  logic [31:0] qB[$];
  int          expCntA = 0;
  int          expCntB = 0;

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endfunction

  function automatic void clearModel();
    qA.delete();
    qB.delete();
    expCntA = 0;
    expCntB = 0;
  endfunction

  // Called at posedge+1; presents one word for a cycle and queues it if it should be taken.
  task automatic applyStimulus(input logic sel, input logic [31:0] data, input logic expReady);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    @(negedge clk);
    checkOutput(sel ? "in_ready(B)" : "in_ready(A)", 32'(bus.in_ready), 32'(expReady));
    @(posedge clk);
    if (expReady) begin
      if (sel == SEL_B) qB.push_back(data);
      else qA.push_back(data);
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rst_n && bus.in_valid)
      assert (!$isunknown(bus.in_sel)) else $error("[TB] in_sel is X while in_valid is high");
  end

  // Monitor: a pop happens at the next posedge whenever valid && ready is seen here.
  initial begin : monitor
    logic popA;
    logic popB;
    forever begin
      @(negedge clk);
      popA = 1'b0;
      popB = 1'b0;
      checkOutput("a_valid", 32'(bus.a_valid), 32'(qA.size() != 0));
      if (bus.a_valid && qA.size() != 0) begin
        checkOutput("a_data", bus.a_data, qA[0]);
        if (bus.a_ready) begin
          void'(qA.pop_front());
          popA = 1'b1;
        end
      end
      checkOutput("b_valid", 32'(bus.b_valid), 32'(qB.size() != 0));
      if (bus.b_valid && qB.size() != 0) begin
        checkOutput("b_data", bus.b_data, qB[0]);
        if (bus.b_ready) begin
          void'(qB.pop_front());
          popB = 1'b1;
        end
      end
      checkOutput("cnt_a", 32'(bus.cnt_a), 32'(expCntA));
      checkOutput("cnt_b", 32'(bus.cnt_b), 32'(expCntB));
      if (popA && expCntA < CNT_MAX) expCntA++;
      if (popB && expCntB < CNT_MAX) expCntB++;
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : main
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel   = SEL_A;
    bus.in_data  = '0;
    bus.a_ready  = 1'b1;
    bus.b_ready  = 1'b1;

    @(negedge clk);
    checkOutput("rst a_valid", 32'(bus.a_valid), 32'd0);
    checkOutput("rst b_valid", 32'(bus.b_valid), 32'd0);
    checkOutput("rst a_data", bus.a_data, 32'd0);
    checkOutput("rst b_data", bus.b_data, 32'd0);
    checkOutput("rst cnt_a", 32'(bus.cnt_a), 32'd0);
    checkOutput("rst cnt_b", 32'(bus.cnt_b), 32'd0);
    checkOutput("rst in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] steering and latency");
    applyStimulus(SEL_A, 32'hDEADBEEF, 1'b1);
    applyStimulus(SEL_B, 32'hCAFEF00D, 1'b1);
    idle(3);
    @(negedge clk);
    checkOutput("steer cnt_a", 32'(bus.cnt_a), 32'd1);
    checkOutput("steer cnt_b", 32'(bus.cnt_b), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] backpressure and isolation");
    bus.a_ready = 1'b0;
    applyStimulus(SEL_A, 32'h10000001, 1'b1);
    applyStimulus(SEL_A, 32'h10000002, 1'b1);
    applyStimulus(SEL_A, 32'h10000003, 1'b0);
    applyStimulus(SEL_B, 32'hB0000001, 1'b1);
    bus.a_ready = 1'b1;
    applyStimulus(SEL_A, 32'h10000003, 1'b0);
    applyStimulus(SEL_A, 32'h10000003, 1'b1);
    idle(4);

    $display("[TB] streaming push/pop on A");
    for (int i = 1; i <= 8; i++) applyStimulus(SEL_A, 32'(i), 1'b1);
    idle(3);

    $display("[TB] head stability under stall");
    bus.a_ready = 1'b0;
    applyStimulus(SEL_A, 32'hA5A5A5A5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall a_valid", 32'(bus.a_valid), 32'd1);
      checkOutput("stall a_data", bus.a_data, 32'hA5A5A5A5);
      @(posedge clk);
      #1;
    end
    bus.a_ready = 1'b1;
    idle(3);

    $display("[TB] reset mid-stream");
    bus.a_ready = 1'b0;
    applyStimulus(SEL_A, 32'h11111111, 1'b1);
    applyStimulus(SEL_A, 32'h22222222, 1'b1);
    #2;
    rst_n = 1'b0;
    clearModel();
    #1;
    checkOutput("midrst a_valid", 32'(bus.a_valid), 32'd0);
    checkOutput("midrst a_data", bus.a_data, 32'd0);
    checkOutput("midrst cnt_a", 32'(bus.cnt_a), 32'd0);
    checkOutput("midrst in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.a_ready = 1'b1;
    idle(2);
    @(negedge clk);
    checkOutput("post-rst a_valid", 32'(bus.a_valid), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] counter saturation on B");
    for (int i = 0; i < 20; i++) applyStimulus(SEL_B, 32'hB1000000 + 32'(i), 1'b1);
    idle(3);
    @(negedge clk);
    checkOutput("sat cnt_b", 32'(bus.cnt_b), 32'd15);
    checkOutput("sat cnt_a", 32'(bus.cnt_a), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(SEL_B, 32'hB2000000, 1'b1);
    idle(3);
    @(negedge clk);
    checkOutput("sat hold cnt_b", 32'(bus.cnt_b), 32'd15);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
